// File: rtl/clmul_if.sv
// Operand/result handshake bundle for the sequential carry-less multiplier.
interface clmul_if #(
  parameter int unsigned K = 4,
  parameter int unsigned N = 2 * K
);
  logic [K-1:0] a;
  logic [K-1:0] b;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/clmul_seq.sv
// Shift-and-XOR GF(2) polynomial multiplier: one multiplier bit per cycle,
// fixed K-cycle latency, result held until the consumer takes it.
module clmul_seq #(
  parameter int unsigned K = 4,
  parameter int unsigned N = 2 * K
) (
  input logic   clk,
  input logic   rst,
  clmul_if.slave bus
);
  localparam int unsigned CW = $clog2(K) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [K-1:0]  mult_q, mult_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  // Next-state and datapath; handshake outputs are decoded from the next state
  // so they can be registered alongside it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = N'(bus.a);
          mult_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (mult_q[0]) acc_d = acc_q ^ mcand_q;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = acc_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_clmul_seq.sv
// Bench for clmul_seq: directed known products plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_clmul_seq;
  localparam int unsigned K = 4;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  clmul_if #(.K(K), .N(N)) bus ();

  clmul_seq #(.K(K), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [N-1:0] clmul(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < int'(K); i++)
      for (int j = 0; j < int'(K); j++)
        if (x[i] && y[j]) p[i+j] = ~p[i+j];
    return p;
  endfunction

  // Transaction model: -1 = waiting for operands, 0..K-1 = edges into the
  // multiply, K = result on offer.
  int           m_cnt  = -1;
  logic [N-1:0] m_prod = '0;
  logic [N-1:0] m_last = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = -1;
      m_prod = '0;
      m_last = '0;
    end else if (m_cnt < 0) begin
      if (bus.in_valid) begin
        m_prod = clmul(bus.a, bus.b);
        m_cnt  = 0;
      end
    end else if (m_cnt < int'(K)) begin
      m_cnt++;
    end else if (bus.out_ready) begin
      m_last = m_prod;
      m_cnt  = -1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_cnt < 0));
      check("out_valid", 64'(bus.out_valid), 64'(m_cnt == int'(K)));
      if (m_cnt < 0) check("out_idle", 64'(bus.out), 64'(m_last));
      else if (m_cnt == int'(K)) check("out_done", 64'(bus.out), 64'(m_prod));
    end
  end

  // Starts at posedge+2; returns at posedge+2 with out_ready still as given.
  task automatic run_op(input logic [K-1:0] ta, input logic [K-1:0] tb_v,
                        input logic [N-1:0] exp, input string nm);
    int n;
    bus.a = ta;
    bus.b = tb_v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check({nm, "_accept_ready"}, 64'(bus.in_ready), 64'd0);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!bus.out_valid) check({nm, "_busy_ready"}, 64'(bus.in_ready), 64'd0);
    end while (!bus.out_valid && n < 20);
    check({nm, "_latency"}, 64'(n), 64'(K));
    check({nm, "_product"}, 64'(bus.out), 64'(exp));
    #1;
  endtask

  int           last_rise;
  logic         prev_valid;
  int           rises;
  logic [N-1:0] held;

  initial begin
    bus.a = '0;
    bus.b = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    #1 rst = 1'b0;

    run_op(4'hB, 4'h7, 8'h31, "b_x_7");
    @(posedge clk); #2;
    run_op(4'hF, 4'hF, 8'h55, "f_x_f");
    check("f_x_f_bit7", 64'(bus.out[N-1]), 64'd0);
    @(posedge clk); #2;
    run_op(4'h8, 4'h8, 8'h40, "8_x_8");
    @(posedge clk); #2;
    run_op(4'h0, 4'h9, 8'h00, "0_x_9");
    @(posedge clk); #2;

    // Consumer stalls while a new request and new operands are presented.
    bus.out_ready = 1'b0;
    run_op(4'h5, 4'h3, 8'h0F, "stall");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      @(posedge clk); #1;
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out", 64'(bus.out), 64'h0F);
      check("stall_ready", 64'(bus.in_ready), 64'd0);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_ready", 64'(bus.in_ready), 64'd1);
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("release_retain", 64'(bus.out), 64'h0F);
    #1;

    // Asynchronous abort during the second multiply cycle.
    bus.a = 4'hB;
    bus.b = 4'h7;
    bus.in_valid = 1'b1;
    @(posedge clk); #2 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out", 64'(bus.out), 64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #2;
    run_op(4'h3, 4'h3, 8'h05, "3_x_3");
    @(posedge clk); #2;

    // Continuous requests with consumer always ready: one result per K+2 edges.
    bus.in_valid = 1'b1;
    last_rise = -1;
    prev_valid = 1'b0;
    rises = 0;
    for (int c = 0; c < 120; c++) begin
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      @(posedge clk); #1;
      if (bus.out_valid && !prev_valid) begin
        if (last_rise >= 0) check("spacing", 64'(c - last_rise), 64'(K + 2));
        last_rise = c;
        rises++;
      end
      prev_valid = bus.out_valid;
      #1;
    end
    check("result_count", 64'(rises >= 19), 64'd1);

    // Random valid/ready traffic; the per-cycle model compare does the work.
    for (int c = 0; c < 800; c++) begin
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
    end

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (K + 3) @(posedge clk);
    held = bus.out;
    #1;
    check("drain_ready", 64'(bus.in_ready), 64'd1);
    check("drain_hold", 64'(bus.out), 64'(held));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/clmul_seq.md
CLMUL_SEQ -- requirements
Module: clmul_seq

Interface
REQ-001 SHALL have parameter K, default 4, giving the operand width in bits.
REQ-002 SHALL have parameter N, default 2*K, giving the product width; 8 matches the reduction stage input it feeds.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port a, input, K, multiplicand polynomial over GF(2), bit i = coefficient of x^i.
REQ-006 SHALL have port b, input, K, multiplier polynomial over GF(2).
REQ-007 SHALL have port in_valid, input, 1, meaning a/b are presented.
REQ-008 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-009 SHALL have port out, output, N, the unreduced carry-less product a*b.
REQ-010 SHALL have port out_valid, output, 1, meaning out holds a completed product.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream consumes out.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 Input transfer SHALL occur on an edge where state=IDLE and in_valid=1.
REQ-015 On transfer: mcand reg (N bits) <= zero-extended a; mult shift reg (K bits) <= b; acc (N bits) <= 0; cnt <= 0; state <= RUN.
REQ-016 Each RUN cycle: if mult[0]=1 then acc <= acc XOR mcand; then mcand <= mcand<<1, mult <= mult>>1, cnt <= cnt+1.
REQ-017 cnt SHALL be clog2(K)+1 bits wide and SHALL never wrap.
REQ-018 RUN SHALL last exactly K cycles regardless of operand values; there is no early exit on mult=0.
REQ-019 On the edge that completes the K-th RUN cycle, state SHALL go to DONE.
REQ-020 out_valid SHALL rise exactly K clock edges after the transfer edge.
REQ-021 out SHALL equal acc.
REQ-022 out SHALL be stable while out_valid=1.
REQ-023 All arithmetic SHALL be XOR only, with no carries.
REQ-024 Bits N-1 down to 2K-1 of out SHALL always be 0.
REQ-025 In DONE, out_valid SHALL be 1; state SHALL move to IDLE on an edge where out_ready=1, otherwise hold.
REQ-026 out_valid SHALL be 0 in IDLE and RUN.
REQ-027 in_valid SHALL be ignored outside IDLE; operands are neither captured nor queued.
REQ-028 A change of a/b during RUN or DONE SHALL NOT affect the result.
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 Minimum spacing between transfers SHALL be K+2 cycles: 1 accept, K run, >=1 done.
REQ-031 out SHALL retain its last product in IDLE until the next transfer clears acc.

Reset
REQ-032 While rst=1, and immediately on assertion without waiting for clk: state=IDLE, acc=0, mcand=0, mult=0, cnt=0.
REQ-033 Reset values SHALL be out=0, out_valid=0 and in_ready=1.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation with no output produced.
REQ-035 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 a=4'hB, b=4'h7, single in_valid pulse -> out_valid high 4 edges later with out=8'h31, in_ready=0 meanwhile.
REQ-037 a=4'hF, b=4'hF -> out=8'h55 with bit 7=0.
REQ-038 a=4'h8, b=4'h8 -> out=8'h40; a=4'h0, b=4'h9 -> out=8'h00, still after exactly 4 RUN cycles.
REQ-039 Back-pressure: out_ready=0 for 3 cycles in DONE with a new in_valid and changed a/b -> out, out_valid stable and no capture; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-040 rst pulsed asynchronously during the 2nd RUN cycle -> out=0, out_valid=0, in_ready=1 before the next clk edge; a fresh a=4'h3, b=4'h3 -> out=8'h05.
REQ-041 Random back-to-back operands with out_ready tied 1 -> every out matches the software carry-less product, one result per 6 cycles.
